scope_capture_buffer: RTL and testbench
=======================================

Name: scope_capture_buffer

Overview:
- Acquisition stage directly upstream of the oscilloscope display/VGA renderer.
- Decimates the incoming 8-bit sample stream according to time_per_div and applies the slope/level edge trigger, with normal or auto mode.
- Captures one screen width of samples into a ping-pong buffer; the display reads the front bank by column address.
- Banks swap only at the display's frame boundary, so the trace never tears.

Parameters:
- DEPTH, 640, samples per capture (one per horizontal pixel)
- AW, 10, address width (2^AW >= DEPTH)
- DW, 8, sample width (matches the 8-bit level input)
- AUTO_TIMEOUT, 2000000, clk cycles spent in WAIT_TRIG before auto mode forces a trigger

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-low reset
- sample_in  in  DW  ADC sample, unsigned
- sample_valid  in  1  one-cycle strobe qualifying sample_in
- slope  in  1  1 = rising-edge trigger, 0 = falling-edge trigger
- mode  in  1  0 = normal, 1 = auto
- level  in  DW  trigger threshold, unsigned
- time_per_div  in  2  decimation select: 0→1, 1→4, 2→16, 3→64
- frame_sync  in  1  one-cycle pulse from the VGA timing block at the start of vertical blanking
- rd_addr  in  AW  display column being read
- rd_data  out  DW  front-bank sample at rd_addr
- buf_ready  out  1  front bank holds a valid capture
- trig_auto  out  1  front-bank capture was forced by the auto timeout
- armed  out  1  high while in WAIT_TRIG

Behaviour:
- Reset (rst=0, async): state=ARM; front bank=0; write address=0; decimation count=0; timeout count=0; prev sample=0; force flag=0; rd_data=0; buf_ready=0; trig_auto=0; armed=0. RAM contents are don't-care.
- Decimator:
  - Counts sample_valid strobes.
  - A decimated sample (dsamp) is produced on the strobe where count >= N-1; count then returns to 0.
  - Comparing with >= lets time_per_div change at any time without a lockup.
  - With N=1, every strobe is a dsamp. Cycles without sample_valid do nothing.
- prev register: loaded with every dsamp, in every state.
- Trigger condition, evaluated on each dsamp x:
  - rising: prev < level and x >= level
  - falling: prev > level and x <= level
  - Equality with level counts as a crossing.
- FSM states:
  - ARM: wait for the first dsamp (loads prev), then go to WAIT_TRIG. Timeout count is cleared on entry to WAIT_TRIG.
  - WAIT_TRIG: armed=1. Timeout count increments every clk and saturates at AUTO_TIMEOUT-1.
    - When saturated and mode=1, the force flag is set. This includes mode rising after saturation.
    - On a dsamp where the trigger condition holds, or force=1: write x to back bank address 0, set write address=1, latch auto = (force and not the real condition), clear force, go to CAPTURE.
  - CAPTURE: each dsamp is written to the back bank at the write address, then the write address increments. The write at address DEPTH-1 moves to FULL.
  - FULL: back bank is frozen. On frame_sync: front bank toggles, buf_ready=1, trig_auto=latched auto, go to ARM.
- frame_sync in ARM, WAIT_TRIG or CAPTURE is ignored.
- frame_sync in the same cycle as the final CAPTURE write is not honoured; the swap waits for the next frame_sync.
- A dsamp in the same cycle as a frame_sync in FULL is discarded. It still loads prev.
- Read port:
  - rd_data is registered with 1-cycle latency: rd_data(t+1) = front[rd_addr(t)].
  - rd_addr >= DEPTH returns 0.
  - Reads never touch the back bank.
- Banks: two DEPTH×DW arrays, or one 2·DEPTH array indexed by the bank bit. Single write port, single read port; inferable as dual-port block RAM.
- Reset mid-capture: returns to ARM immediately and buf_ready drops to 0. The display must blank when buf_ready=0.
- Input changes mid-capture: changes to slope, level or mode during CAPTURE or FULL affect only the next arm.

Test Plan:
1. Rising trigger. Stimulus: time_per_div=0, slope=1, mode=0, level=128; ramp 0..255 repeating, one sample per 4 clks; frame_sync after FULL. Required: front[0]=128, front[k]=(128+k) mod 256, buf_ready=1, trig_auto=0.
2. Falling trigger with decimation. Stimulus: time_per_div=1, slope=0, level=100; descending ramp 255..0 repeating, every sample valid. Required: front[0]=100, front[k]=(100-4k) mod 256, i.e. every 4th input sample.
3. Auto mode. Stimulus: mode=1, level=200, constant input 50, AUTO_TIMEOUT set to 1000. Required: capture starts at the first dsamp after 1000 WAIT_TRIG cycles; after swap all 640 entries=50 and trig_auto=1. Repeat with mode=0: required to stay armed=1 indefinitely with buf_ready=0.
4. Swap timing. Stimulus: frame_sync in the same cycle as the final CAPTURE write. Required: no swap; swap on the next frame_sync; old front data readable until then with 1-cycle rd_data latency; rd_addr=700 returns 0.
5. Reset mid-capture. Stimulus: assert rst at write address 300. Required: all outputs at reset values asynchronously; after release, the first capture completes normally (repeat case 1 results).
6. Tear-freedom. Stimulus: continuous reads of rd_addr 0..639 while the back bank fills with a different waveform. Required: rd_data matches the previous capture until frame_sync swap, then the new one.

Source files
------------

// File: rtl/scope_capture_buffer.sv
// Oscilloscope acquisition stage: decimation, slope/level trigger with auto mode,
// and a ping-pong capture buffer whose banks swap only on the display frame boundary.
module scope_capture_buffer #(
  parameter int unsigned DEPTH        = 640,
  parameter int unsigned AW           = 10,
  parameter int unsigned DW           = 8,
  parameter int unsigned AUTO_TIMEOUT = 2000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  input  logic          slope,
  input  logic          mode,
  input  logic [DW-1:0] level,
  input  logic [1:0]    time_per_div,
  input  logic          frame_sync,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          buf_ready,
  output logic          trig_auto,
  output logic          armed
);

  localparam int unsigned   TW        = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_MAX    = TW'(AUTO_TIMEOUT - 1);
  localparam int unsigned   MW        = AW + 1;
  localparam logic [MW-1:0] BANK_OFS  = MW'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {ARM, WAIT_TRIG, CAPTURE, FULL} state_e;

  state_e        state_q, state_d;
  logic          front_q, front_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [5:0]    dcnt_q, dcnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [DW-1:0] prev_q, prev_d;
  logic          force_q, force_d;
  logic          auto_q, auto_d;
  logic          buf_ready_q, buf_ready_d;
  logic          trig_auto_q, trig_auto_d;
  logic [DW-1:0] rd_data_q;

  logic [5:0]    dec_last;
  logic          dsamp, cond, fire, last_wr;
  logic          we;
  logic [AW-1:0] waddr;
  logic [MW-1:0] wr_idx, rd_idx;
  logic          rd_in_range;

  logic [DW-1:0] mem_q [2*DEPTH];

  always_comb begin
    case (time_per_div)
      2'd0:    dec_last = 6'd0;
      2'd1:    dec_last = 6'd3;
      2'd2:    dec_last = 6'd15;
      default: dec_last = 6'd63;
    endcase
  end

  // >= rather than == so a lowered decimation ratio never strands the counter
  assign dsamp   = sample_valid && (dcnt_q >= dec_last);
  assign cond    = slope ? ((prev_q < level) && (sample_in >= level))
                         : ((prev_q > level) && (sample_in <= level));
  assign fire    = dsamp && (cond || force_q);
  assign last_wr = (wr_addr_q == LAST_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ARM;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARM:       if (dsamp)             state_d = WAIT_TRIG;
      WAIT_TRIG: if (fire)              state_d = CAPTURE;
      CAPTURE:   if (dsamp && last_wr)  state_d = FULL;
      FULL:      if (frame_sync)        state_d = ARM;
      default:                          state_d = ARM;
    endcase
  end

  always_comb begin
    armed = (state_q == WAIT_TRIG);
    we    = 1'b0;
    waddr = wr_addr_q;
    case (state_q)
      WAIT_TRIG: begin
        we    = fire;
        waddr = '0;
      end
      CAPTURE: we = dsamp;
      default: ;
    endcase
  end

  always_comb begin
    front_d     = front_q;
    wr_addr_d   = wr_addr_q;
    dcnt_d      = dcnt_q;
    to_d        = to_q;
    prev_d      = dsamp ? sample_in : prev_q;
    force_d     = force_q;
    auto_d      = auto_q;
    buf_ready_d = buf_ready_q;
    trig_auto_d = trig_auto_q;
    if (sample_valid) dcnt_d = dsamp ? 6'd0 : dcnt_q + 6'd1;
    case (state_q)
      ARM: if (dsamp) to_d = '0;
      WAIT_TRIG: begin
        if (to_q != TO_MAX) to_d = to_q + TW'(1);
        if (fire) begin
          wr_addr_d = AW'(1);
          auto_d    = force_q && !cond;
          force_d   = 1'b0;
        end else if ((to_q == TO_MAX) && mode) begin
          force_d = 1'b1;
        end
      end
      CAPTURE: if (dsamp) wr_addr_d = last_wr ? '0 : wr_addr_q + AW'(1);
      FULL: if (frame_sync) begin
        front_d     = ~front_q;
        buf_ready_d = 1'b1;
        trig_auto_d = auto_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front_q     <= 1'b0;
      wr_addr_q   <= '0;
      dcnt_q      <= '0;
      to_q        <= '0;
      prev_q      <= '0;
      force_q     <= 1'b0;
      auto_q      <= 1'b0;
      buf_ready_q <= 1'b0;
      trig_auto_q <= 1'b0;
    end else begin
      front_q     <= front_d;
      wr_addr_q   <= wr_addr_d;
      dcnt_q      <= dcnt_d;
      to_q        <= to_d;
      prev_q      <= prev_d;
      force_q     <= force_d;
      auto_q      <= auto_d;
      buf_ready_q <= buf_ready_d;
      trig_auto_q <= trig_auto_d;
    end
  end

  // Bank b occupies [b*DEPTH, b*DEPTH+DEPTH); writes go to the bank not shown
  assign wr_idx      = {1'b0, waddr} + (front_q ? '0 : BANK_OFS);
  assign rd_idx      = {1'b0, rd_addr} + (front_q ? BANK_OFS : '0);
  assign rd_in_range = ({1'b0, rd_addr} < BANK_OFS);

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_idx] <= sample_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             rd_data_q <= '0;
    else if (rd_in_range) rd_data_q <= mem_q[rd_idx];
    else                  rd_data_q <= '0;
  end

  assign rd_data   = rd_data_q;
  assign buf_ready = buf_ready_q;
  assign trig_auto = trig_auto_q;

endmodule

// File: tb/tb_scope_capture_buffer.sv
// Scoreboard bench for scope_capture_buffer: a dsamp-history model predicts the
// front bank contents and status outputs; a monitor compares every issued cycle.
module tb_scope_capture_buffer;
  localparam int DEPTH = 640;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample_in = '0;
  logic       sample_valid = 1'b0;
  logic       slope = 1'b1;
  logic       mode = 1'b0;
  logic [7:0] level = '0;
  logic [1:0] time_per_div = '0;
  logic       frame_sync = 1'b0;
  logic [9:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       buf_ready, trig_auto, armed;

  scope_capture_buffer #(.DEPTH(640), .AW(10), .DW(8), .AUTO_TIMEOUT(1000)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .slope(slope), .mode(mode), .level(level), .time_per_div(time_per_div),
    .frame_sync(frame_sync), .rd_addr(rd_addr), .rd_data(rd_data),
    .buf_ready(buf_ready), .trig_auto(trig_auto), .armed(armed));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
  endfunction

  // Reference model: history of decimated samples since reset, plus arm/trigger indices
  int  d[$];
  int  nstrobe;
  bit  arm_pending;
  int  arm_idx, trig_idx;
  int  front[DEPTH];
  bit  front_known, front_ready, front_auto;
  int  swaps = 0;
  bit  st_en = 1'b1;

  function automatic int dec_n();
    return 1 << (2 * int'(time_per_div));
  endfunction

  function automatic bit crosses(input int p, input int x);
    if (slope) return (p < int'(level)) && (x >= int'(level));
    else       return (p > int'(level)) && (x <= int'(level));
  endfunction

  function automatic bit cap_full();
    return (trig_idx >= 0) && (d.size() >= trig_idx + DEPTH);
  endfunction

  function automatic bit final_now(input bit v);
    return v && (((nstrobe + 1) % dec_n()) == 0) && (trig_idx >= 0) &&
           (d.size() + 1 == trig_idx + DEPTH);
  endfunction

  function automatic void model_reset();
    d.delete();
    nstrobe = 0; arm_pending = 1'b1; arm_idx = -1; trig_idx = -1;
    front_known = 1'b0; front_ready = 1'b0; front_auto = 1'b0;
  endfunction

  function automatic void model_cycle(input bit v, input int x, input bit fs);
    bit swapped = 1'b0;
    int i;
    if (fs && cap_full()) begin
      for (int k = 0; k < DEPTH; k++) front[k] = d[trig_idx + k];
      front_known = 1'b1; front_ready = 1'b1; front_auto = 1'b0;
      arm_pending = 1'b1; trig_idx = -1; swaps++; swapped = 1'b1;
    end
    if (v) begin
      nstrobe++;
      if ((nstrobe % dec_n()) == 0) begin
        d.push_back(x);
        i = d.size() - 1;
        if (arm_pending) begin
          if (!swapped) begin arm_pending = 1'b0; arm_idx = i; end
        end else if (trig_idx < 0 && i > arm_idx && crosses(d[i-1], x)) begin
          trig_idx = i;
        end
      end
    end
  endfunction

  typedef struct { bit rchk; int rd; bit schk; bit br; bit ta; bit ar; } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  bit   issue = 1'b0;
  bit   issued_q = 1'b0;

  always @(posedge clk) issued_q <= issue;

  always @(negedge clk) begin
    if (issued_q) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL scoreboard_empty: got 0 entries, expected 1");
      end else begin
        mon_e = sb_q.pop_front();
        if (rst) begin
          if (mon_e.rchk) chk("rd_data", int'(rd_data), mon_e.rd);
          if (mon_e.schk) begin
            chk("buf_ready", int'(buf_ready), int'(mon_e.br));
            chk("trig_auto", int'(trig_auto), int'(mon_e.ta));
            chk("armed", int'(armed), int'(mon_e.ar));
          end
        end
      end
    end
  end

  task automatic cyc(input bit v, input int x, input bit fs, input bit re, input int ra);
    exp_t e;
    sample_valid = v; sample_in = x[7:0]; frame_sync = fs; rd_addr = ra[9:0];
    e.rchk = re && (ra >= DEPTH || front_known);
    e.rd   = 0;
    if (ra < DEPTH) e.rd = front[ra];
    model_cycle(v, x, fs);
    e.schk = st_en; e.br = front_ready; e.ta = front_auto;
    e.ar   = !arm_pending && trig_idx < 0;
    sb_q.push_back(e);
    issue = 1'b1;
    @(posedge clk); #1;
    issue = 1'b0; sample_valid = 1'b0; frame_sync = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_buf_ready", int'(buf_ready), 0);
    chk("rst_trig_auto", int'(trig_auto), 0);
    chk("rst_armed", int'(armed), 0);
  endtask

  function automatic int gen(input int kind, input int sidx);
    case (kind)
      0:       return sidx % 256;
      1:       return 255 - (sidx % 256);
      2:       return int'($urandom_range(0, 255));
      default: return 50;
    endcase
  endfunction

  // kind: 0 ramp up, 1 ramp down, 2 random; reads sweep 0..703 throughout
  task automatic run_capture(input int kind, input int gap, input bit same_cycle_fs);
    int start = swaps;
    int sidx = 0, cnum = 0, ra = 0, wait_c = 5, budget = 40000, x = 0;
    bit v, fs;
    while (swaps == start && budget > 0) begin
      v = (kind == 2) ? ($urandom_range(0, gap - 1) == 0) : ((cnum % gap) == 0);
      x = 0;
      if (v) begin x = gen(kind, sidx); sidx++; end
      fs = 1'b0;
      if (same_cycle_fs) begin
        if (final_now(v)) fs = 1'b1;
        else if (cap_full()) begin
          if (wait_c > 0) wait_c--;
          else fs = 1'b1;
        end
      end else begin
        fs = cap_full();
      end
      cyc(v, x, fs, 1'b1, ra);
      ra = (ra + 1) % 704;
      cnum++; budget--;
    end
    if (swaps == start) begin
      n_chk++;
      $display("FAIL capture_budget: got 0 swaps, expected 1");
    end
  endtask

  task automatic sweep();
    for (int a = 0; a < 704; a++) cyc(1'b0, 0, 1'b0, 1'b1, a);
  endtask

  initial begin
    int budget;
    #1 rst = 1'b0;
    #1 check_reset_outputs();

    // Rising trigger on a slow ramp
    time_per_div = 2'd0; slope = 1'b1; mode = 1'b0; level = 8'd128;
    do_reset();
    run_capture(0, 4, 1'b0);
    sweep();

    // Random falling-edge data; frame_sync coincides with the final write
    slope = 1'b0; level = 8'($urandom_range(60, 190));
    run_capture(2, 3, 1'b1);
    sweep();

    // Reset mid-capture at write address 300, then a clean repeat
    slope = 1'b1; level = 8'd128;
    budget = 5000;
    for (int c = 0; budget > 0 && !(trig_idx >= 0 && d.size() == trig_idx + 300); c++) begin
      cyc((c % 4) == 0, ((c / 4) % 256), 1'b0, 1'b1, c % 704);
      budget--;
    end
    if (budget == 0) begin
      n_chk++;
      $display("FAIL midcap_budget: got 0, expected write address 300");
    end
    #2 rst = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    run_capture(0, 4, 1'b0);
    sweep();

    // Falling trigger with 4:1 decimation on a descending ramp
    time_per_div = 2'd1; slope = 1'b0; level = 8'd100;
    do_reset();
    run_capture(1, 1, 1'b0);
    sweep();

    // 16:1 decimation, random data, rising
    time_per_div = 2'd2; slope = 1'b1; level = 8'($urandom_range(60, 190));
    do_reset();
    run_capture(2, 2, 1'b0);
    sweep();

    // Auto mode: no real crossing, forced after the timeout
    time_per_div = 2'd0; mode = 1'b1; level = 8'd200; slope = 1'b1;
    do_reset();
    st_en = 1'b0;
    for (int i = 0; i < 995; i++) cyc(1'b1, 50, 1'b0, 1'b0, 0);
    chk("auto_still_armed", int'(armed), 1);
    chk("auto_no_buf_yet", int'(buf_ready), 0);
    for (int i = 0; i < 15; i++) cyc(1'b1, 50, 1'b0, 1'b0, 0);
    chk("auto_forced", int'(armed), 0);
    for (int i = 0; i < 700; i++) cyc(1'b1, 50, 1'b0, 1'b0, 0);
    cyc(1'b0, 0, 1'b1, 1'b0, 0);
    for (int k = 0; k < DEPTH; k++) front[k] = 50;
    front_known = 1'b1; front_ready = 1'b1; front_auto = 1'b1;
    arm_pending = 1'b1; trig_idx = -1;
    st_en = 1'b1;
    sweep();

    // Normal mode with no crossing stays armed without a capture
    mode = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) cyc(1'b1, 50, 1'b0, 1'b1, i % 704);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
